// File: rtl/ext_bus_pkg.sv
// Shared EXT-bus definitions: initiator FSM states, byte-enable codes and default address step.
// Types and constants only, so there is no latency and no flow control here.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR,
        DONE
    } ext_state_t;

    localparam logic [3:0] WEA_NONE      = 4'h0;
    localparam logic [3:0] WEA_FULL      = 4'hF;
    localparam int         ADDR_STEP_DEF = 4;

endpackage

// File: rtl/ext_dma_initiator.sv
// EXT-bus block copier: one word per read/wait/write triple; done pulses 3N+1 cycles after start.
// No backpressure: the outside arbiter must leave the bus granted for the whole transfer.
module ext_dma_initiator
    import ext_bus_pkg::*;
#(
    parameter int AWIDTH    = 16,
    parameter int LEN_WIDTH = 8,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AWIDTH-1:0]    src_addr,
    input  logic [AWIDTH-1:0]    dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 ext_en,
    output logic [3:0]           ext_wea,
    output logic [AWIDTH-1:0]    ext_addr,
    output logic [31:0]          ext_din,
    input  logic [31:0]          ext_dout
);

    ext_state_t           state, state_nxt;
    logic [AWIDTH-1:0]    src_ptr, dst_ptr, src_nxt, dst_nxt;
    logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
    logic                 abort_hit;
    logic                 busy_nxt, done_nxt, en_nxt;
    logic [3:0]           wea_nxt;
    logic [AWIDTH-1:0]    addr_nxt;
    logic [31:0]          din_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        cnt_nxt   = cnt;
        abort_hit = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_nxt = RD;
                        src_nxt   = src_addr;
                        dst_nxt   = dst_addr;
                        cnt_nxt   = len;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RD:   state_nxt = WT;
            WT:   state_nxt = WR;
            WR: begin
                src_nxt   = src_ptr + AWIDTH'(ADDR_STEP);
                dst_nxt   = dst_ptr + AWIDTH'(ADDR_STEP);
                cnt_nxt   = cnt - LEN_WIDTH'(1);
                state_nxt = (cnt == LEN_WIDTH'(1)) ? DONE : RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The write already on the bus in WR completes; abort only steers the next state.
        if (abort && (state == RD || state == WT || state == WR)) begin
            state_nxt = DONE;
            abort_hit = 1'b1;
        end

        // Outputs are decoded from the next state so the registers present them in that state.
        busy_nxt = (state_nxt == RD) || (state_nxt == WT) || (state_nxt == WR);
        done_nxt = (state_nxt == DONE);
        en_nxt   = (state_nxt == RD) || (state_nxt == WR);
        wea_nxt  = (state_nxt == WR) ? WEA_FULL : WEA_NONE;

        addr_nxt = ext_addr;
        if (state_nxt == RD || state_nxt == WT) begin
            addr_nxt = src_nxt;
        end else if (state_nxt == WR) begin
            addr_nxt = dst_nxt;
        end

        din_nxt = ext_din;
        if (state == WT) begin
            din_nxt = ext_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            ext_en   <= 1'b0;
            ext_wea  <= WEA_NONE;
            ext_addr <= '0;
            ext_din  <= '0;
        end else begin
            src_ptr  <= src_nxt;
            dst_ptr  <= dst_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            aborted  <= abort_hit;
            ext_en   <= en_nxt;
            ext_wea  <= wea_nxt;
            ext_addr <= addr_nxt;
            ext_din  <= din_nxt;
        end
    end

endmodule

// File: tb/tb_ext_dma_initiator.sv
// Bench for ext_dma_initiator: directed scenarios plus randomized copies checked against a sequential copy model.
// The responder is a registered-address word memory; unwritten words read back as an address-derived pattern.
module tb_ext_dma_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, aborted, ext_en;
    logic [3:0]  ext_wea;
    logic [15:0] ext_addr;
    logic [31:0] ext_din;
    logic [31:0] ext_dout = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [0:16383];
    bit          mem_v   [0:16383];
    logic [31:0] ref_mem [0:16383];
    bit          ref_v   [0:16383];

    int          rd_cyc[$];
    logic [15:0] rd_adr[$];
    int          wr_cyc[$];
    logic [15:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          done_cyc;
    bit          ab_seen;
    int          ab_stray;
    int          busy_cnt;
    bit          idle_after;

    ext_dma_initiator dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .ext_en   (ext_en),
        .ext_wea  (ext_wea),
        .ext_addr (ext_addr),
        .ext_din  (ext_din),
        .ext_dout (ext_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A3C_96E1;
    endfunction

    always @(posedge clk) begin
        if (ext_en && ext_wea == 4'hF) begin
            mem[ext_addr[15:2]]   <= ext_din;
            mem_v[ext_addr[15:2]] <= 1'b1;
        end
        ext_dout <= mem_v[ext_addr[15:2]] ? mem[ext_addr[15:2]] : pat(ext_addr);
    end

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_v[a[15:2]] ? ref_mem[a[15:2]] : pat(a);
    endfunction

    task automatic do_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n, input int abort_at);
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        done_cyc = -1; ab_seen = 0; ab_stray = 0; busy_cnt = 0; idle_after = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom);
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            abort = (c == abort_at);
            if (ext_en && ext_wea == 4'h0) begin rd_cyc.push_back(c); rd_adr.push_back(ext_addr); end
            if (ext_en && ext_wea == 4'hF) begin
                wr_cyc.push_back(c); wr_adr.push_back(ext_addr); wr_dat.push_back(ext_din);
            end
            if (busy) busy_cnt++;
            if (aborted && !done) ab_stray++;
            if (done) begin done_cyc = c; ab_seen = aborted; break; end
        end
        abort = 1'b0;
        @(negedge clk);
        idle_after = !busy && !done && !ext_en && !aborted;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din} !== 57'd0) begin
            errors++; $display("FAIL reset_hold outputs got %h exp 0", {busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din} !== 57'd0) begin
            errors++; $display("FAIL reset_idle outputs got %h exp 0", {busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din});
        end
    endtask

    task automatic test_copy();
        do_xfer(16'h0400, 16'h0440, 8'd3, -1);
        checks++;
        if (rd_cyc.size() != 3 || wr_cyc.size() != 3) begin
            errors++; $display("FAIL copy_counts reads %0d writes %0d exp 3 3", rd_cyc.size(), wr_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd_cyc[k] != 3*k+1 || rd_adr[k] !== 16'(16'h0400 + 4*k)) begin
                    errors++; $display("FAIL copy_read%0d got c%0d @%h exp c%0d @%h", k, rd_cyc[k], rd_adr[k], 3*k+1, 16'(16'h0400 + 4*k));
                end
                checks++;
                if (wr_cyc[k] != 3*k+3 || wr_adr[k] !== 16'(16'h0440 + 4*k) || wr_dat[k] !== pat(16'(16'h0400 + 4*k))) begin
                    errors++; $display("FAIL copy_write%0d got c%0d @%h %h exp c%0d @%h %h", k, wr_cyc[k], wr_adr[k], wr_dat[k],
                                       3*k+3, 16'(16'h0440 + 4*k), pat(16'(16'h0400 + 4*k)));
                end
            end
        end
        checks++;
        if (done_cyc != 10 || ab_seen || !idle_after || busy_cnt != 9) begin
            errors++; $display("FAIL copy_done got c%0d ab%0d idle%0d busy%0d exp c10 ab0 idle1 busy9", done_cyc, ab_seen, idle_after, busy_cnt);
        end
    endtask

    task automatic test_len_zero();
        do_xfer(16'h0400, 16'h0480, 8'd0, -1);
        checks++;
        if (done_cyc != 1 || rd_cyc.size() != 0 || wr_cyc.size() != 0 || busy_cnt != 0 || ab_seen || !idle_after) begin
            errors++; $display("FAIL len_zero done c%0d rd %0d wr %0d busy %0d ab %0d exp c1 0 0 0 0",
                               done_cyc, rd_cyc.size(), wr_cyc.size(), busy_cnt, ab_seen);
        end
    endtask

    task automatic test_wrap();
        do_xfer(16'hFFFC, 16'h0700, 8'd2, -1);
        checks++;
        if (rd_adr.size() != 2 || rd_adr[0] !== 16'hFFFC || rd_adr[1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_read got %0d reads second @%h exp 2 reads second @0000", rd_adr.size(), rd_adr[1]);
        end
        checks++;
        if (wr_dat.size() != 2 || wr_dat[1] !== pat(16'h0000) || wr_adr[1] !== 16'h0704) begin
            errors++; $display("FAIL wrap_write got %0d writes %h @%h exp 2 writes %h @0704", wr_dat.size(), wr_dat[1], wr_adr[1], pat(16'h0000));
        end
    endtask

    task automatic test_abort();
        do_xfer(16'h0480, 16'h04C0, 8'd4, 5);
        checks++;
        if (rd_cyc.size() != 2 || wr_cyc.size() != 1 || wr_cyc[0] != 3) begin
            errors++; $display("FAIL abort_traffic got rd %0d wr %0d exp rd 2 wr 1 at c3", rd_cyc.size(), wr_cyc.size());
        end
        checks++;
        if (done_cyc != 6 || !ab_seen || ab_stray != 0 || !idle_after) begin
            errors++; $display("FAIL abort_done got c%0d ab%0d stray%0d idle%0d exp c6 ab1 stray0 idle1", done_cyc, ab_seen, ab_stray, idle_after);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        start = 1'b1; src_addr = 16'h0540; dst_addr = 16'h0560; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ext_wea !== 4'hF || ext_addr !== 16'h0560) begin
            errors++; $display("FAIL rst_mid_wr got wea %h @%h exp F @0560", ext_wea, ext_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din} !== 57'd0) begin
            errors++; $display("FAIL rst_mid_zero outputs got %h exp 0", {busy, done, aborted, ext_en, ext_wea, ext_addr, ext_din});
        end
        rst = 1'b0;
        do_xfer(16'h0580, 16'h05C0, 8'd1, -1);
        checks++;
        if (done_cyc != 4 || wr_cyc.size() != 1 || wr_adr[0] !== 16'h05C0 || wr_dat[0] !== pat(16'h0580)) begin
            errors++; $display("FAIL rst_mid_after done c%0d wr %0d @%h %h exp c4 1 @05c0 %h",
                               done_cyc, wr_cyc.size(), wr_adr[0], wr_dat[0], pat(16'h0580));
        end
    endtask

    task automatic test_start_held();
        int          rc[$];
        logic [15:0] ra[$];
        int          wc[$];
        logic [15:0] wa[$];
        int          dc[$];
        @(negedge clk);
        start = 1'b1; src_addr = 16'h0500; dst_addr = 16'h0600; len = 8'd1;
        @(posedge clk); #1;
        src_addr = 16'h0510; dst_addr = 16'h0610; len = 8'd1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (ext_en && ext_wea == 4'h0) begin rc.push_back(c); ra.push_back(ext_addr); end
            if (ext_en && ext_wea == 4'hF) begin wc.push_back(c); wa.push_back(ext_addr); end
            if (done) dc.push_back(c);
            if (c == 6) start = 1'b0;
        end
        checks++;
        if (rc.size() != 2 || rc[0] != 1 || ra[0] !== 16'h0500 || rc[1] != 6 || ra[1] !== 16'h0510) begin
            errors++; $display("FAIL held_reads got %0d reads c%0d @%h c%0d @%h exp c1 @0500 c6 @0510", rc.size(), rc[0], ra[0], rc[1], ra[1]);
        end
        checks++;
        if (wc.size() != 2 || wc[0] != 3 || wa[0] !== 16'h0600 || wc[1] != 8 || wa[1] !== 16'h0610) begin
            errors++; $display("FAIL held_writes got %0d writes c%0d @%h c%0d @%h exp c3 @0600 c8 @0610", wc.size(), wc[0], wa[0], wc[1], wa[1]);
        end
        checks++;
        if (dc.size() != 2 || dc[0] != 4 || dc[1] != 9) begin
            errors++; $display("FAIL held_done got %0d pulses c%0d c%0d exp c4 c9", dc.size(), dc[0], dc[1]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            logic [7:0]  n;
            logic [15:0] s, d, a;
            logic [31:0] w;
            int          ab, last, nr, nw;
            n  = 8'($urandom_range(0, 16));
            s  = 16'h8000 | (16'($urandom) & 16'h7FFC);
            d  = 16'h8000 | (16'($urandom) & 16'h7FFC);
            ab = -1;
            if (n != 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 3*int'(n)));
            do_xfer(s, d, n, ab);

            last = (n == 0) ? 0 : ((ab > 0) ? ab : 3*int'(n));
            nr = 0; nw = 0;
            for (int k = 0; k < int'(n); k++) begin
                if (3*k+1 <= last) nr++;
                if (3*k+3 <= last) nw++;
            end
            checks++;
            if (rd_cyc.size() != nr || wr_cyc.size() != nw) begin
                errors++; $display("FAIL rand%0d_counts got rd %0d wr %0d exp rd %0d wr %0d", it, rd_cyc.size(), wr_cyc.size(), nr, nw);
            end else begin
                for (int k = 0; k < nr; k++) begin
                    a = 16'(s + 16'(4*k));
                    checks++;
                    if (rd_cyc[k] != 3*k+1 || rd_adr[k] !== a) begin
                        errors++; $display("FAIL rand%0d_read%0d got c%0d @%h exp c%0d @%h", it, k, rd_cyc[k], rd_adr[k], 3*k+1, a);
                    end
                end
                for (int k = 0; k < nw; k++) begin
                    w = ref_rd(16'(s + 16'(4*k)));
                    a = 16'(d + 16'(4*k));
                    ref_mem[a[15:2]] = w;
                    ref_v[a[15:2]]   = 1'b1;
                    checks++;
                    if (wr_cyc[k] != 3*k+3 || wr_adr[k] !== a || wr_dat[k] !== w) begin
                        errors++; $display("FAIL rand%0d_write%0d got c%0d @%h %h exp c%0d @%h %h", it, k, wr_cyc[k], wr_adr[k], wr_dat[k], 3*k+3, a, w);
                    end
                end
            end
            checks++;
            if (done_cyc != last+1 || ab_seen != (ab > 0) || ab_stray != 0 || busy_cnt != last || !idle_after) begin
                errors++; $display("FAIL rand%0d_done got c%0d ab%0d busy%0d idle%0d exp c%0d ab%0d busy%0d idle1",
                                   it, done_cyc, ab_seen, busy_cnt, idle_after, last+1, (ab > 0), last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_len_zero();
        test_wrap();
        test_abort();
        test_rst_mid();
        test_start_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
